// File: rtl/elevator_scheduler.sv
// elevator_scheduler: car sequencing controller. Latches call-button presses,
// picks a target floor, runs travel/door phases on move_clk ticks, and
// enforces the SOS and overload interlocks.
// Build option: define ELEVATOR_COLLECTIVE_EN for collective (SCAN) scheduling;
// leave it undefined for fixed-priority (lowest pending floor) scheduling.
module elevator_scheduler #(
  parameter int NUM_FLOORS      = 3,
  parameter int TICKS_PER_FLOOR = 2,
  parameter int DOOR_TICKS      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] buttons,
  input  logic                  move_clk,
  input  logic                  sos_mode,
  input  logic                  weight_limit_exceeded,
  output logic [2:0]            floor,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_DOWN = 3'd2,
    S_DOOR = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [2:0] TOP_FLOOR  = 3'(NUM_FLOORS - 1);
  localparam logic [3:0] TRAVEL_END = 4'(TICKS_PER_FLOOR - 1);
  localparam logic [3:0] DOOR_END   = 4'(DOOR_TICKS - 1);

  state_t                state_reg, state_next;
  logic [2:0]            floor_reg, floor_next;
  logic                  dir_up_reg, dir_up_next;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;
  logic [3:0]            travel_cnt_reg, travel_cnt_next;
  logic [3:0]            door_cnt_reg, door_cnt_next;
  logic                  move_clk_q_reg;
  logic                  tick;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  logic [2:0]            pick, new_floor;
  logic                  stop_hit, go_on;

`ifndef ELEVATOR_COLLECTIVE_EN
  logic [2:0]            target_reg, target_next;
`endif

  // One-hot mask of a floor index.
  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i == int'(f)) m[i] = 1'b1;
    return m;
  endfunction

`ifdef ELEVATOR_COLLECTIVE_EN
  // {found, floor} of the nearest pending floor above f.
  function automatic logic [3:0] nearest_up(input logic [NUM_FLOORS-1:0] p,
                                            input logic [2:0] f);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (p[i] && (i > int'(f))) r = {1'b1, 3'(i)};
    return r;
  endfunction

  // {found, floor} of the nearest pending floor below f.
  function automatic logic [3:0] nearest_dn(input logic [NUM_FLOORS-1:0] p,
                                            input logic [2:0] f);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (p[i] && (i < int'(f))) r = {1'b1, 3'(i)};
    return r;
  endfunction
`else
  // Lowest-index set bit of p.
  function automatic logic [2:0] lowest_set(input logic [NUM_FLOORS-1:0] p);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (p[i]) r = 3'(i);
    return r;
  endfunction
`endif

  // Per-button 2-flop synchronizer plus a history flop for 1->0 detection.
  // Flops reset to "pressed" so a button held through reset is not a new press.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_sync
      logic s1_reg, s2_reg, s3_reg;
      // Synchronize the raw button and keep the previous synchronized value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
          s3_reg <= 1'b0;
        end else begin
          s1_reg <= buttons[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end
      assign press[gi] = s3_reg & ~s2_reg;
    end
  endgenerate

  // Registered copy of move_clk for rising-edge tick detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) move_clk_q_reg <= 1'b0;
    else        move_clk_q_reg <= move_clk;
  end

  assign tick = move_clk & ~move_clk_q_reg;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      floor_reg      <= '0;
      dir_up_reg     <= 1'b1;
      pending_reg    <= '0;
      travel_cnt_reg <= '0;
      door_cnt_reg   <= '0;
`ifndef ELEVATOR_COLLECTIVE_EN
      target_reg     <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      floor_reg      <= floor_next;
      dir_up_reg     <= dir_up_next;
      pending_reg    <= pending_next;
      travel_cnt_reg <= travel_cnt_next;
      door_cnt_reg   <= door_cnt_next;
`ifndef ELEVATOR_COLLECTIVE_EN
      target_reg     <= target_next;
`endif
    end
  end

  // Next-state, scheduling and request bookkeeping.
  always_comb begin
    state_next      = state_reg;
    floor_next      = floor_reg;
    dir_up_next     = dir_up_reg;
    travel_cnt_next = travel_cnt_reg;
    door_cnt_next   = door_cnt_reg;
`ifndef ELEVATOR_COLLECTIVE_EN
    target_next     = target_reg;
`endif
    set_mask        = press;
    clr_mask        = '0;
    pick            = floor_reg;
    new_floor       = floor_reg;
    stop_hit        = 1'b0;
    go_on           = 1'b0;

    if (sos_mode) begin
      // Emergency stop overrides everything and drops all requests.
      state_next      = S_HALT;
      travel_cnt_next = '0;
      door_cnt_next   = '0;
      set_mask        = '0;
      clr_mask        = '1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pending_reg != '0) begin
`ifdef ELEVATOR_COLLECTIVE_EN
            if ((pending_reg & onehot(floor_reg)) != '0)
              pick = floor_reg;
            else if (dir_up_reg ? nearest_up(pending_reg, floor_reg)[3]
                                : nearest_dn(pending_reg, floor_reg)[3])
              pick = dir_up_reg ? nearest_up(pending_reg, floor_reg)[2:0]
                                : nearest_dn(pending_reg, floor_reg)[2:0];
            else
              pick = dir_up_reg ? nearest_dn(pending_reg, floor_reg)[2:0]
                                : nearest_up(pending_reg, floor_reg)[2:0];
`else
            pick        = lowest_set(pending_reg);
            target_next = pick;
`endif
            travel_cnt_next = '0;
            if (pick == floor_reg) begin
              state_next    = S_DOOR;
              door_cnt_next = '0;
              clr_mask      = onehot(floor_reg);
            end else if (pick > floor_reg) begin
              state_next  = S_UP;
              dir_up_next = 1'b1;
            end else begin
              state_next  = S_DOWN;
              dir_up_next = 1'b0;
            end
          end
        end

        S_UP, S_DOWN: begin
          if (tick) begin
            if (travel_cnt_reg >= TRAVEL_END) begin
              travel_cnt_next = '0;
              if ((state_reg == S_UP) ? (floor_reg >= TOP_FLOOR) : (floor_reg == 3'd0)) begin
                // Already at the shaft limit: never drive floor out of range.
                state_next = S_IDLE;
              end else begin
                new_floor  = (state_reg == S_UP) ? floor_reg + 3'd1 : floor_reg - 3'd1;
                floor_next = new_floor;
`ifdef ELEVATOR_COLLECTIVE_EN
                stop_hit = (pending_reg & onehot(new_floor)) != '0;
                go_on    = (state_reg == S_UP) ? nearest_up(pending_reg, new_floor)[3]
                                               : nearest_dn(pending_reg, new_floor)[3];
`else
                stop_hit = (new_floor == target_reg);
                go_on    = (state_reg == S_UP) ? (new_floor != TOP_FLOOR)
                                               : (new_floor != 3'd0);
`endif
                if (stop_hit) begin
                  state_next    = S_DOOR;
                  door_cnt_next = '0;
                  clr_mask      = onehot(new_floor);
                end else if (!go_on) begin
                  state_next = S_IDLE;
                end
              end
            end else begin
              travel_cnt_next = travel_cnt_reg + 4'd1;
            end
          end
        end

        S_DOOR: begin
          // A call for this floor reopens the door instead of queueing.
          set_mask = press & ~onehot(floor_reg);
          if ((press & onehot(floor_reg)) != '0) begin
            door_cnt_next = '0;
          end else if (weight_limit_exceeded) begin
            door_cnt_next = '0;
          end else if (tick) begin
            if (door_cnt_reg >= DOOR_END) begin
              door_cnt_next = '0;
              state_next    = S_IDLE;
            end else begin
              door_cnt_next = door_cnt_reg + 4'd1;
            end
          end
        end

        S_HALT: begin
          set_mask   = '0;
          state_next = S_IDLE;
        end

        default: state_next = S_IDLE;
      endcase
    end

    // An arrival clear beats a same-edge press for the same floor.
    pending_next = (pending_reg | set_mask) & ~clr_mask;
  end

  assign floor     = floor_reg;
  assign moving    = (state_reg == S_UP) || (state_reg == S_DOWN);
  assign dir_up    = dir_up_reg;
  assign door_open = (state_reg == S_DOOR);
  assign pending   = pending_reg;
  assign halted    = (state_reg == S_HALT);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler (default parameters:
// 3 floors, 2 ticks per floor, 3 door ticks). Follows ELEVATOR_COLLECTIVE_EN
// for the scheduling-dependent expectations.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] buttons = 3'b000;
  logic       move_clk = 1'b0;
  logic       sos_mode = 1'b0;
  logic       weight_limit_exceeded = 1'b0;
  logic [2:0] floor;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic [2:0] pending;
  logic       halted;

  int checks = 0;
  int failures = 0;
  int cf = 0;          // floor the car rests at between scenarios
  logic [2:0] exp_p;

  elevator_scheduler dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .buttons               (buttons),
    .move_clk              (move_clk),
    .sos_mode              (sos_mode),
    .weight_limit_exceeded (weight_limit_exceeded),
    .floor                 (floor),
    .moving                (moving),
    .dir_up                (dir_up),
    .door_open             (door_open),
    .pending               (pending),
    .halted                (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One move_clk pulse: high for one cycle (the tick edge), low for one.
  task automatic pulse_tick(input int n);
    for (int k = 0; k < n; k++) begin
      move_clk = 1'b1;
      cyc(1);
      move_clk = 1'b0;
      cyc(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    buttons = 3'b000;
    cyc(4);
    checks++; if (floor !== 3'd0) begin failures++; $display("FAIL reset_floor: got %0d expected 0", floor); end
    checks++; if (moving !== 1'b0) begin failures++; $display("FAIL reset_moving: got %b expected 0", moving); end
    checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL reset_dir_up: got %b expected 1", dir_up); end
    checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL reset_door: got %b expected 0", door_open); end
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL reset_pending: got %b expected 000", pending); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
    rst_n = 1'b1;
    cyc(5);
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL reset_held_pending: got %b expected 000", pending); end
    checks++; if (moving !== 1'b0 || door_open !== 1'b0) begin failures++; $display("FAIL reset_held_idle: got moving=%b door=%b expected 0 0", moving, door_open); end
    buttons = 3'b111;
    cyc(4);
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL reset_release_pending: got %b expected 000", pending); end
    $display("test_reset done");
  endtask

  task automatic test_single_call;
    buttons[2] = 1'b0;
    cyc(2);
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL call_latency_early: got %b expected 000", pending); end
    cyc(1);
    checks++; if (pending !== 3'b100) begin failures++; $display("FAIL call_pending: got %b expected 100", pending); end
    checks++; if (moving !== 1'b0) begin failures++; $display("FAIL call_not_yet_moving: got %b expected 0", moving); end
    buttons[2] = 1'b1;
    cyc(1);
    checks++; if (moving !== 1'b1 || dir_up !== 1'b1) begin failures++; $display("FAIL call_moving_up: got moving=%b dir_up=%b expected 1 1", moving, dir_up); end
    pulse_tick(1);
    checks++; if (floor !== 3'd0) begin failures++; $display("FAIL call_half_floor: got %0d expected 0", floor); end
    pulse_tick(1);
    checks++; if (floor !== 3'd1 || moving !== 1'b1) begin failures++; $display("FAIL call_floor1: got floor=%0d moving=%b expected 1 1", floor, moving); end
    pulse_tick(2);
    checks++; if (floor !== 3'd2 || door_open !== 1'b1 || pending !== 3'b000 || moving !== 1'b0) begin
      failures++; $display("FAIL call_arrive: got floor=%0d door=%b pending=%b moving=%b expected 2 1 000 0", floor, door_open, pending, moving);
    end
    pulse_tick(2);
    checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL call_door_2ticks: got %b expected 1", door_open); end
    pulse_tick(1);
    checks++; if (door_open !== 1'b0 || moving !== 1'b0) begin failures++; $display("FAIL call_door_close: got door=%b moving=%b expected 0 0", door_open, moving); end
    $display("test_single_call done floor=%0d", floor);
  endtask

  task automatic test_scheduling;
    buttons[0] = 1'b0;
    cyc(3);
    checks++; if (pending !== 3'b001) begin failures++; $display("FAIL sched_pending0: got %b expected 001", pending); end
    buttons[0] = 1'b1;
    cyc(1);
    checks++; if (moving !== 1'b1 || dir_up !== 1'b0) begin failures++; $display("FAIL sched_moving_down: got moving=%b dir_up=%b expected 1 0", moving, dir_up); end
    buttons[1] = 1'b0;
    cyc(3);
    checks++; if (pending !== 3'b011) begin failures++; $display("FAIL sched_pending01: got %b expected 011", pending); end
    buttons[1] = 1'b1;
    pulse_tick(2);
`ifdef ELEVATOR_COLLECTIVE_EN
    checks++; if (floor !== 3'd1 || door_open !== 1'b1 || pending !== 3'b001) begin
      failures++; $display("FAIL sched_stop1: got floor=%0d door=%b pending=%b expected 1 1 001", floor, door_open, pending);
    end
    pulse_tick(3);
    checks++; if (moving !== 1'b1 || dir_up !== 1'b0) begin failures++; $display("FAIL sched_resume_down: got moving=%b dir_up=%b expected 1 0", moving, dir_up); end
    pulse_tick(2);
    checks++; if (floor !== 3'd0 || door_open !== 1'b1 || pending !== 3'b000) begin
      failures++; $display("FAIL sched_stop0: got floor=%0d door=%b pending=%b expected 0 1 000", floor, door_open, pending);
    end
    pulse_tick(3);
    cf = 0;
`else
    checks++; if (floor !== 3'd1 || moving !== 1'b1 || pending !== 3'b011) begin
      failures++; $display("FAIL sched_pass1: got floor=%0d moving=%b pending=%b expected 1 1 011", floor, moving, pending);
    end
    pulse_tick(2);
    checks++; if (floor !== 3'd0 || door_open !== 1'b1 || pending !== 3'b010) begin
      failures++; $display("FAIL sched_stop0: got floor=%0d door=%b pending=%b expected 0 1 010", floor, door_open, pending);
    end
    pulse_tick(3);
    checks++; if (moving !== 1'b1 || dir_up !== 1'b1) begin failures++; $display("FAIL sched_serve1_up: got moving=%b dir_up=%b expected 1 1", moving, dir_up); end
    pulse_tick(2);
    checks++; if (floor !== 3'd1 || door_open !== 1'b1 || pending !== 3'b000) begin
      failures++; $display("FAIL sched_stop1: got floor=%0d door=%b pending=%b expected 1 1 000", floor, door_open, pending);
    end
    pulse_tick(3);
    cf = 1;
`endif
    checks++; if (door_open !== 1'b0 || moving !== 1'b0) begin failures++; $display("FAIL sched_idle: got door=%b moving=%b expected 0 0", door_open, moving); end
    $display("test_scheduling done floor=%0d", floor);
  endtask

  task automatic test_same_floor;
    exp_p = 3'b001 << cf;
    buttons[cf] = 1'b0;
    cyc(3);
    checks++; if (pending !== exp_p) begin failures++; $display("FAIL same_pending: got %b expected %b", pending, exp_p); end
    cyc(1);
    checks++; if (door_open !== 1'b1 || moving !== 1'b0 || pending !== 3'b000 || floor !== 3'(cf)) begin
      failures++; $display("FAIL same_door: got door=%b moving=%b pending=%b floor=%0d expected 1 0 000 %0d", door_open, moving, pending, floor, cf);
    end
    buttons[cf] = 1'b1;
    pulse_tick(2);
    buttons[cf] = 1'b0;
    cyc(3);
    buttons[cf] = 1'b1;
    checks++; if (pending !== 3'b000 || door_open !== 1'b1) begin failures++; $display("FAIL same_repress: got pending=%b door=%b expected 000 1", pending, door_open); end
    pulse_tick(2);
    checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL same_restart_open: got %b expected 1", door_open); end
    pulse_tick(1);
    checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL same_restart_close: got %b expected 0", door_open); end
    $display("test_same_floor done");
  endtask

  task automatic test_overload;
    buttons[cf] = 1'b0;
    cyc(4);
    buttons[cf] = 1'b1;
    checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL overload_door_entry: got %b expected 1", door_open); end
    weight_limit_exceeded = 1'b1;
    pulse_tick(10);
    checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL overload_held: got %b expected 1", door_open); end
    weight_limit_exceeded = 1'b0;
    pulse_tick(2);
    checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL overload_release_open: got %b expected 1", door_open); end
    pulse_tick(1);
    checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL overload_release_close: got %b expected 0", door_open); end
    $display("test_overload done");
  endtask

  task automatic test_async_reset;
    buttons[2] = 1'b0;
    cyc(4);
    checks++; if (moving !== 1'b1) begin failures++; $display("FAIL areset_moving: got %b expected 1", moving); end
    pulse_tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (floor !== 3'd0 || moving !== 1'b0 || dir_up !== 1'b1 || door_open !== 1'b0 || pending !== 3'b000 || halted !== 1'b0) begin
      failures++; $display("FAIL areset_outputs: got floor=%0d moving=%b dir_up=%b door=%b pending=%b halted=%b expected 0 0 1 0 000 0",
                           floor, moving, dir_up, door_open, pending, halted);
    end
    buttons = 3'b111;
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    checks++; if (pending !== 3'b000 || moving !== 1'b0) begin failures++; $display("FAIL areset_after: got pending=%b moving=%b expected 000 0", pending, moving); end
    $display("test_async_reset done");
  endtask

  task automatic test_sos;
    buttons = 3'b001;
    cyc(3);
    checks++; if (pending !== 3'b110) begin failures++; $display("FAIL sos_pending_pre: got %b expected 110", pending); end
    buttons = 3'b111;
    cyc(1);
    checks++; if (moving !== 1'b1) begin failures++; $display("FAIL sos_moving_pre: got %b expected 1", moving); end
    pulse_tick(1);
    sos_mode = 1'b1;
    cyc(1);
    checks++; if (halted !== 1'b1 || moving !== 1'b0 || pending !== 3'b000 || floor !== 3'd0) begin
      failures++; $display("FAIL sos_halt: got halted=%b moving=%b pending=%b floor=%0d expected 1 0 000 0", halted, moving, pending, floor);
    end
    buttons[0] = 1'b0;
    cyc(3);
    buttons[0] = 1'b1;
    cyc(1);
    checks++; if (pending !== 3'b000 || halted !== 1'b1) begin failures++; $display("FAIL sos_ignore_press: got pending=%b halted=%b expected 000 1", pending, halted); end
    sos_mode = 1'b0;
    cyc(1);
    checks++; if (halted !== 1'b0 || moving !== 1'b0 || door_open !== 1'b0) begin
      failures++; $display("FAIL sos_exit_idle: got halted=%b moving=%b door=%b expected 0 0 0", halted, moving, door_open);
    end
    buttons[1] = 1'b0;
    cyc(3);
    checks++; if (pending !== 3'b010) begin failures++; $display("FAIL sos_new_press: got %b expected 010", pending); end
    buttons[1] = 1'b1;
    cyc(1);
    pulse_tick(1);
    checks++; if (floor !== 3'd0 || moving !== 1'b1) begin failures++; $display("FAIL sos_travel_restart: got floor=%0d moving=%b expected 0 1", floor, moving); end
    pulse_tick(1);
    checks++; if (floor !== 3'd1 || door_open !== 1'b1 || pending !== 3'b000) begin
      failures++; $display("FAIL sos_served: got floor=%0d door=%b pending=%b expected 1 1 000", floor, door_open, pending);
    end
    pulse_tick(3);
    $display("test_sos done");
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scheduling();
    test_same_floor();
    test_overload();
    test_async_reset();
    test_sos();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Sequencing controller for the car. It latches floor-call button presses as pending requests and picks the next target floor. It runs the car through travel and door phases, counting rising edges of `move_clk` from the frequency/move tick generator. It also enforces the SOS and weight-limit interlocks, and it drives the floor indicator and the `moving` flag that the tick generator consumes.

## Interface
- `NUM_FLOORS`, default 3: number of floors, legal 2–8.
- `TICKS_PER_FLOOR`, default 2: `move_clk` rising edges needed to travel one floor, legal 1–15.
- `DOOR_TICKS`, default 3: `move_clk` rising edges the door stays open, legal 1–15.
- `clk` in 1: system clock; all state is on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `buttons` in `NUM_FLOORS`: call buttons, active-low (0 = pressed), asynchronous to `clk`.
- `move_clk` in 1: tick from the move generator, synchronous to `clk`.
- `sos_mode` in 1: emergency stop, active-high.
- `weight_limit_exceeded` in 1: overload, active-high.
- `floor` out 3: current floor index (0-based).
- `moving` out 1: 1 in state UP or DOWN.
- `dir_up` out 1: last or current travel direction (1 = up).
- `door_open` out 1: 1 in state DOOR.
- `pending` out `NUM_FLOORS`: latched, unserved requests.
- `halted` out 1: 1 in state HALT.

## Operation
- **Button input.** `buttons` passes through a 2-flop synchronizer per bit. A 1→0 transition of the synchronized bit sets `pending[i]`. A held button does not re-trigger.
- **Tick.** `tick = move_clk & ~move_clk_q`, where `move_clk_q` is registered.
- **States:** IDLE, UP, DOWN, DOOR, HALT.
- **IDLE.** If `pending == 0`, stay. Otherwise choose `target` (see Configuration), then:
  - `target == floor` → DOOR, and clear `pending[floor]`.
  - `target > floor` → UP, `dir_up = 1`.
  - `target < floor` → DOWN, `dir_up = 0`.
- **UP/DOWN.**
  - Each tick increments `travel_cnt` (4 bits).
  - On the tick where `travel_cnt` reaches `TICKS_PER_FLOOR`: `travel_cnt` returns to 0 and `floor` goes ±1.
  - If the new floor is a stop floor, enter DOOR and clear that pending bit on the same edge.
  - `floor` is never driven outside 0..`NUM_FLOORS-1`. If no request lies beyond the limit, the car stops at the limit and returns to IDLE.
- **DOOR.**
  - Each tick increments `door_cnt`. On reaching `DOOR_TICKS`: `door_cnt` returns to 0 and the state goes to IDLE.
  - While `weight_limit_exceeded = 1`, `door_cnt` is held at 0 and the door stays open.
  - A press for the current floor in DOOR restarts `door_cnt` and does not set pending.
- **UP/DOWN under overload.** `weight_limit_exceeded` is ignored; the car finishes its travel.
- **HALT.**
  - `sos_mode = 1` in any state enters HALT on the next edge.
  - Entry clears `pending`, `travel_cnt` and `door_cnt`. `floor` keeps the last reached floor.
  - Presses are ignored while in HALT.
  - When `sos_mode` drops to 0, the state goes to IDLE.
- **Simultaneous events.**
  - SOS has priority over everything.
  - An arrival clear and a new press for the same floor on the same edge: the clear wins, and the door is already opening.
  - A press for any other floor on the same edge is latched.

## Timing
- **Reset values:** `floor = 0`, `moving = 0`, `dir_up = 1`, `door_open = 0`, `pending = 0`, `halted = 0`. All counters and state are cleared, and the state is IDLE.
- **Button latency:** press to `pending` bit set is 3 `clk` cycles (2 synchronizer stages plus the latch).
- **IDLE decision:** 1 cycle from `pending != 0` to `moving` or `door_open`.
- **Tick latency:** `move_clk` rising at edge *n* produces `tick` in cycle *n*. `floor`, `door_open` and `pending` update at edge *n+1*.
- **Travel time:** one floor takes `TICKS_PER_FLOOR` ticks. The door is open for `DOOR_TICKS` ticks after any holds.
- **SOS latency:** `sos_mode` high to `halted = 1` and `moving = 0` is 1 cycle.
- **Reset mid-operation:** all outputs return to their reset values asynchronously.

## Configuration
- **`ELEVATOR_COLLECTIVE_EN` defined (collective/SCAN scheduling).**
  - The target is the nearest pending floor in the `dir_up` direction. If there is none, it is the nearest pending floor in the opposite direction, and `dir_up` flips.
  - During travel, the car stops at every floor whose pending bit is set.
- **`ELEVATOR_COLLECTIVE_EN` undefined (fixed-priority scheduling).**
  - The target is the lowest-index set bit of `pending`, latched when leaving IDLE.
  - The car stops only at that target. Intermediate pending floors are passed and stay set.

## Test plan
- **Reset:** hold `rst_n = 0` with buttons active → all outputs at reset values; release → IDLE, `pending = 0`.
- **Single call:** at floor 0, press `buttons[2]` → `pending = 3'b100` after 3 cycles. `moving` rises 1 cycle later. `floor` reaches 2 after 4 ticks, then `door_open = 1` and `pending = 0`. After 3 ticks the state is IDLE.
- **Scheduling, car at floor 2:** press floors 0 then 1 while moving down from 2.
  - With macro: stops at 1, then at 0.
  - Without macro: stops only at 0 (the latched target); `pending[1]` stays set and floor 1 is served afterwards.
- **Overload:** hold `weight_limit_exceeded` in DOOR for 10 ticks → `door_open` stays 1. Release → door closes after 3 more ticks.
- **SOS mid-travel:** assert `sos_mode` halfway between floors 0 and 1 → `halted = 1` and `moving = 0` next cycle, `pending = 0`, `floor = 0`. Deassert → IDLE; a new press is honoured.
- **Same-floor call:** press the current floor in IDLE → DOOR without moving. Press it again during DOOR → `door_cnt` restarts and `pending` stays 0.
